pu_riscv_biu_ahb: RTL and testbench



---
 rtl/pu_riscv_biu_ahb_if.sv | 52 +++++
 rtl/pu_riscv_biu_ahb.sv | 188 ++++++++++++++++++
 tb/tb_pu_riscv_biu_ahb.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_riscv_biu_ahb_if.sv
`default_nettype none
// ============================================================================
// pu_riscv_biu_ahb_if : BIU request bundle plus AHB-Lite master bus signals
// Revision 1.0
// ============================================================================
interface pu_riscv_biu_ahb_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  // requester side
  logic            biu_stb;
  logic            biu_stb_ack;
  logic [PLEN-1:0] biu_adri;
  logic [PLEN-1:0] biu_adro;
  logic [2:0]      biu_size;
  logic [2:0]      biu_type;
  logic            biu_lock;
  logic [2:0]      biu_prot;
  logic            biu_we;
  logic [XLEN-1:0] biu_d;
  logic [XLEN-1:0] biu_q;
  logic            biu_ack;
  logic            biu_err;

  // AHB-Lite bus
  logic [PLEN-1:0] HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    input  biu_stb, biu_adri, biu_size, biu_type, biu_lock, biu_prot, biu_we, biu_d,
    input  HRDATA, HREADY, HRESP,
    output biu_stb_ack, biu_adro, biu_q, biu_ack, biu_err,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );

  modport slave (
    output biu_stb, biu_adri, biu_size, biu_type, biu_lock, biu_prot, biu_we, biu_d,
    output HRDATA, HREADY, HRESP,
    input  biu_stb_ack, biu_adro, biu_q, biu_ack, biu_err,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );
endinterface
`default_nettype wire

// File: rtl/pu_riscv_biu_ahb.sv
`default_nettype none
// ============================================================================
// pu_riscv_biu_ahb : BIU strobe/ack to AHB-Lite master, bursts/waits/ERROR
// Revision 1.0
// ============================================================================
module pu_riscv_biu_ahb #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pu_riscv_biu_ahb_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR2  = 2'd2
  } state_t;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      2'b11:   return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            hold_q;
  logic [1:0]      trans_q;
  logic [PLEN-1:0] addr_q;
  logic            we_q;
  logic [2:0]      size_q;
  logic [2:0]      burst_q;
  logic [2:0]      prot_q;
  logic            lock_q;
  logic            dp_valid_q;
  logic [PLEN-1:0] dp_addr_q;
  logic [XLEN-1:0] dp_wdata_q;

  logic            w_req;
  logic            w_err1;
  logic            w_done;
  logic            w_accept;
  logic [PLEN-1:0] w_step;
  logic [PLEN-1:0] w_incr;
  logic [PLEN-1:0] w_mask;
  logic [PLEN-1:0] w_next;
  logic [1:0]      w_trans;
  logic [PLEN-1:0] w_addr;
  logic            w_we;
  logic [2:0]      w_size;
  logic [2:0]      w_burst;
  logic [2:0]      w_prot;
  logic            w_lock;

  // A request seen while reset is high must not leak onto the bus
  assign w_req    = bus.biu_stb & ~rst_i;
  assign w_err1   = dp_valid_q & bus.HRESP & ~bus.HREADY;
  assign w_done   = dp_valid_q & bus.HREADY;
  assign w_accept = w_trans[1] & bus.HREADY;

  // Next beat address; wrap bursts keep bits above the wrap boundary
  always_comb begin
    w_step = PLEN'(1) << size_q;
    w_incr = addr_q + w_step;
    w_mask = ((PLEN'(burst_beats_m1(burst_q)) + PLEN'(1)) << size_q) - PLEN'(1);
    if (!burst_q[0]) w_next = (addr_q & ~w_mask) | (w_incr & w_mask);
    else             w_next = w_incr;
  end

  always_comb begin
    w_trans = c_HTRANS_IDLE;
    w_addr  = addr_q;
    w_we    = we_q;
    w_size  = size_q;
    w_burst = burst_q;
    w_prot  = prot_q;
    w_lock  = lock_q;
    if (w_err1 || state_q == ST_ERR2) begin
      w_trans = c_HTRANS_IDLE;
    end else if (hold_q) begin
      w_trans = trans_q;
    end else if (state_q == ST_BURST) begin
      if (w_req) begin
        w_trans = c_HTRANS_SEQ;
        w_addr  = w_next;
      end else begin
        w_trans = c_HTRANS_BUSY;
      end
    end else if (w_req) begin
      w_trans = c_HTRANS_NONSEQ;
      w_addr  = bus.biu_adri;
      w_we    = bus.biu_we;
      w_size  = bus.biu_size;
      w_burst = bus.biu_type;
      w_prot  = bus.biu_prot;
      w_lock  = bus.biu_lock;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      hold_q     <= 1'b0;
      trans_q    <= c_HTRANS_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      burst_q    <= 3'd0;
      prot_q     <= 3'd0;
      lock_q     <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_wdata_q <= '0;
    end else begin
      // Copy of the last presented address phase, replayed while stalled
      if (w_trans[1]) begin
        addr_q  <= w_addr;
        we_q    <= w_we;
        size_q  <= w_size;
        burst_q <= w_burst;
        prot_q  <= w_prot;
        lock_q  <= w_lock;
        trans_q <= w_trans;
      end
      hold_q <= w_trans[1] & ~bus.HREADY;

      if (w_accept) begin
        dp_valid_q <= 1'b1;
        dp_addr_q  <= w_addr;
        dp_wdata_q <= bus.biu_d;
      end else if (w_done) begin
        dp_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_err1) begin
            cnt_q   <= 4'd0;
            state_q <= ST_ERR2;
          end else if (w_accept && w_burst[2:1] != 2'b00) begin
            cnt_q   <= burst_beats_m1(w_burst);
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_err1) begin
            cnt_q   <= 4'd0;
            state_q <= ST_ERR2;
          end else if (w_accept) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= ST_IDLE;
          end
        end
        ST_ERR2: begin
          if (bus.HREADY) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.HTRANS      = w_trans;
  assign bus.HADDR       = w_addr;
  assign bus.HWRITE      = w_we;
  assign bus.HSIZE       = w_size;
  assign bus.HBURST      = w_burst;
  assign bus.HPROT       = {1'b0, w_prot};
  assign bus.HMASTLOCK   = w_lock;
  assign bus.HWDATA      = dp_wdata_q;
  assign bus.biu_stb_ack = w_accept;
  assign bus.biu_adro    = dp_addr_q;
  assign bus.biu_q       = bus.HRDATA;
  assign bus.biu_ack     = w_done & ~bus.HRESP;
  assign bus.biu_err     = w_done & bus.HRESP;

endmodule
`default_nettype wire

// File: tb/tb_pu_riscv_biu_ahb.sv
`default_nettype none
// ============================================================================
// tb_pu_riscv_biu_ahb : random requester + random AHB slave, queue scoreboard
// Revision 1.0
// ============================================================================
module tb_pu_riscv_biu_ahb;
  localparam int XLEN = 64;
  localparam int PLEN = 64;

  logic clk = 1'b0;
  logic rst;
  bit   rst_test = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pu_riscv_biu_ahb_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

  pu_riscv_biu_ahb #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  trans;
    logic        we;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [2:0]  prot;
    logic        lock;
  } aexp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } dexp_t;

  aexp_t aq[$];
  dexp_t dq[$];
  bit    sresp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int n_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  // Reference beat address from the burst rules, written as plain arithmetic
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input int size,
                                            input logic [2:0] burst, input int k);
    longint unsigned bytes, bnd, base;
    bytes = 64'd1 << size;
    if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
      bnd  = longint'(n_beats(burst)) * bytes;
      base = start - (start % bnd);
      return base + ((start - base + longint'(k) * bytes) % bnd);
    end
    return start + longint'(k) * bytes;
  endfunction

  function automatic logic [63:0] rd_pat(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // ---------------- AHB slave: random waits, occasional two-cycle ERROR
  initial begin : slave
    bit active, done, acc, err, nw, w;
    int idx, waits;
    logic [63:0] na, a;
    active = 0; idx = 0; waits = 0; err = 0; w = 0; a = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    forever begin
      @(negedge clk);
      done = active && bus.HREADY;
      acc  = bus.HTRANS[1] && bus.HREADY;
      na   = bus.HADDR;
      nw   = bus.HWRITE;
      @(posedge clk);
      #1;
      if (rst) begin
        active = 0;
        sresp_q.delete();
      end else begin
        if (active && !done) idx++;
        if (done) active = 0;
        if (acc) begin
          active = 1; idx = 0;
          waits  = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 2));
          err    = ($urandom % 10 == 0);
          a = na; w = nw;
          sresp_q.push_back(err);
        end
      end
      if (!active) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = {$urandom, $urandom};
      end else if (idx < waits) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0; bus.HRDATA = {$urandom, $urandom};
      end else if (err) begin
        bus.HRESP = 1'b1; bus.HREADY = (idx > waits);
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        bus.HRDATA = w ? {$urandom, $urandom} : rd_pat(a);
      end
    end
  end

  // ---------------- address-phase monitor
  bit          prev_pend = 0;
  logic [63:0] prev_addr;
  logic [1:0]  prev_trans;

  always @(negedge clk) begin : mon_a
    aexp_t e;
    if (rst || rst_test) begin
      prev_pend = 0;
    end else begin
      chk("stb_ack", bus.biu_stb_ack, bus.HTRANS[1] & bus.HREADY);
      if (bus.HRESP && !bus.HREADY) chk("err1_htrans_idle", bus.HTRANS, 2'd0);
      else if (prev_pend) begin
        chk("hold_haddr", bus.HADDR, prev_addr);
        chk("hold_htrans", bus.HTRANS, prev_trans);
      end
      if (bus.HTRANS[1] && bus.HREADY) begin
        if (aq.size() == 0) chk("unexpected_addr_phase", 1, 0);
        else begin
          e = aq.pop_front();
          chk("haddr", bus.HADDR, e.addr);
          chk("htrans", bus.HTRANS, e.trans);
          chk("hwrite", bus.HWRITE, e.we);
          chk("hsize", bus.HSIZE, e.size);
          chk("hburst", bus.HBURST, e.burst);
          chk("hprot", bus.HPROT, {1'b0, e.prot});
          chk("hmastlock", bus.HMASTLOCK, e.lock);
        end
      end
      prev_pend  = bus.HTRANS[1] && !bus.HREADY;
      prev_addr  = bus.HADDR;
      prev_trans = bus.HTRANS;
    end
  end

  // ---------------- data-phase monitor
  always @(negedge clk) begin : mon_d
    dexp_t d;
    bit    e;
    if (!rst && !rst_test && (bus.biu_ack || bus.biu_err)) begin
      chk("ack_err_exclusive", bus.biu_ack & bus.biu_err, 1'b0);
      if (dq.size() == 0 || sresp_q.size() == 0) chk("unexpected_response", 1, 0);
      else begin
        d = dq.pop_front();
        e = sresp_q.pop_front();
        chk("resp_is_err", bus.biu_err, e);
        if (!e) begin
          chk("adro", bus.biu_adro, d.addr);
          if (d.we) chk("hwdata", bus.HWDATA, d.wdata);
          else      chk("rdata", bus.biu_q, rd_pat(d.addr));
        end
      end
    end
  end

  // ---------------- requester
  task automatic run_txn(input logic [63:0] start, input int size, input logic [2:0] burst,
                         input bit we, input int gap_at, input int gap_len);
    int          nb;
    bit          ab, got;
    logic [2:0]  prot;
    bit          lock;
    logic [63:0] d;
    aexp_t       ae;
    dexp_t       de;
    nb = n_beats(burst); ab = 0;
    prot = 3'($urandom); lock = ($urandom % 8 == 0);
    for (int k = 0; k < nb && !ab; k++) begin
      if (k > 0 && k == gap_at) begin
        for (int i = 0; i < gap_len && !ab; i++) begin
          bus.biu_stb = 1'b0;
          @(negedge clk);
          if (bus.biu_err) ab = 1;
          else if (!bus.HRESP) begin
            chk("busy_htrans", bus.HTRANS, 2'd1);
            chk("busy_haddr", bus.HADDR, beat_addr(start, size, burst, k - 1));
          end
          @(posedge clk);
          #1;
        end
      end
      if (!ab) begin
        d = {$urandom, $urandom};
        bus.biu_stb  = 1'b1;
        bus.biu_adri = (k == 0) ? start : {$urandom, $urandom};
        bus.biu_size = 3'(size);
        bus.biu_type = burst;
        bus.biu_we   = we;
        bus.biu_prot = prot;
        bus.biu_lock = lock;
        bus.biu_d    = d;
        ae.addr = beat_addr(start, size, burst, k);
        ae.trans = (k == 0) ? 2'd2 : 2'd3;
        ae.we = we; ae.size = 3'(size); ae.burst = burst; ae.prot = prot; ae.lock = lock;
        aq.push_back(ae);
        de.addr = ae.addr; de.we = we; de.wdata = d;
        dq.push_back(de);
        got = 0;
        for (int t = 0; t < 64 && !got && !ab; t++) begin
          @(negedge clk);
          if (bus.biu_err) begin
            ab = 1;
            if (aq.size() > 0) void'(aq.pop_back());
            if (dq.size() > 0) void'(dq.pop_back());
          end else if (bus.biu_stb_ack) got = 1;
          @(posedge clk);
          #1;
        end
        if (!got && !ab) begin
          chk("stb_ack_timeout", 0, 1);
          ab = 1;
        end
      end
    end
    bus.biu_stb = 1'b0;
  endtask

  initial begin : main
    int          sz, nb, ga, gl;
    logic [2:0]  bt;
    logic [63:0] ad;
    bit          got;
    bus.biu_stb = 1'b1; bus.biu_adri = 64'hFFFF_0000_1234_5678; bus.biu_size = 3'd2;
    bus.biu_type = 3'd3; bus.biu_lock = 1'b1; bus.biu_prot = 3'd7; bus.biu_we = 1'b1;
    bus.biu_d = '1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", bus.HTRANS, 2'd0);
    chk("rst_haddr", bus.HADDR, 64'd0);
    chk("rst_hwrite", bus.HWRITE, 1'b0);
    chk("rst_hsize", bus.HSIZE, 3'd0);
    chk("rst_hburst", bus.HBURST, 3'd0);
    chk("rst_hprot", bus.HPROT, 4'd0);
    chk("rst_hmastlock", bus.HMASTLOCK, 1'b0);
    chk("rst_hwdata", bus.HWDATA, 64'd0);
    chk("rst_stb_ack", bus.biu_stb_ack, 1'b0);
    chk("rst_ack", bus.biu_ack, 1'b0);
    chk("rst_err", bus.biu_err, 1'b0);
    chk("rst_adro", bus.biu_adro, 64'd0);
    @(posedge clk);
    #1;
    bus.biu_stb = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed cases, then random traffic
    run_txn(64'h1000, 2, 3'd0, 1'b0, -1, 0);
    run_txn(64'h2000, 0, 3'd0, 1'b1, -1, 0);
    run_txn(64'h1008, 2, 3'd2, 1'b0, -1, 0);
    run_txn(64'h3000, 3, 3'd5, 1'b0, 3, 2);
    run_txn(64'h4000, 2, 3'd3, 1'b1, 2, 1);
    run_txn(64'h10F0, 3, 3'd6, 1'b1, 5, 3);
    run_txn(64'h5004, 2, 3'd1, 1'b0, -1, 0);
    for (int n = 0; n < 250; n++) begin
      sz = int'($urandom_range(0, 3));
      bt = 3'($urandom);
      ad = {$urandom, $urandom} & ~((64'd1 << sz) - 64'd1);
      nb = n_beats(bt);
      ga = (nb > 1 && $urandom % 3 == 0) ? int'($urandom_range(1, nb - 1)) : -1;
      gl = int'($urandom_range(1, 3));
      run_txn(ad, sz, bt, 1'($urandom), ga, gl);
      if ($urandom % 4 == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 100 && dq.size() > 0; i++) @(negedge clk);
    chk("addr_queue_drained", aq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    chk("slave_queue_drained", sresp_q.size(), 0);

    // reset during the data phase of a read
    @(posedge clk);
    #1;
    rst_test = 1'b1;
    bus.biu_stb = 1'b1; bus.biu_adri = 64'h1000; bus.biu_size = 3'd2;
    bus.biu_type = 3'd0; bus.biu_we = 1'b0; bus.biu_lock = 1'b0; bus.biu_prot = 3'd3;
    got = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      got = bus.biu_stb_ack;
      @(posedge clk);
      #1;
    end
    chk("rsttest_accept", got, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_htrans", bus.HTRANS, 2'd0);
    chk("async_rst_haddr", bus.HADDR, 64'd0);
    chk("async_rst_ack", bus.biu_ack, 1'b0);
    chk("async_rst_stb_ack", bus.biu_stb_ack, 1'b0);
    chk("async_rst_adro", bus.biu_adro, 64'd0);
    bus.biu_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_ack", bus.biu_ack, 1'b0);
      chk("post_rst_no_err", bus.biu_err, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
